if_stage: RTL

//  Instruction-fetch front end: PC register driving the instruction ROM (ce, pc) and IF/ID pipeline

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage_if_id.sv | 48 ++++
 rtl/if_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: legacy define.v values and FSM encodings.
package if_stage_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;

    localparam logic [1:0] StRst  = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

endpackage

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: captures the fetched pc/instruction, bubbles on flush or a stall split.
module if_stage_if_id
    import if_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus,
    parameter int unsigned INST_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              flush,
    input  logic [1:0]        stall,  // [0]=IF/ID hold, [1]=ID hold
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
);

    logic [ADDR_W-1:0] id_pc_d, id_pc_q;
    logic [INST_W-1:0] id_inst_d, id_inst_q;

    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        // A disabled ROM masks the reset pc so nothing spurious reaches decode.
        if (!ce || flush || (stall[0] && !stall[1])) begin
            id_pc_d   = '0;
            id_inst_d = '0;
        end else if (!stall[0]) begin
            id_pc_d   = pc;
            id_inst_d = inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            id_pc_q   <= '0;
            id_inst_q <= '0;
        end else begin
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
        end
    end

    assign id_pc   = id_pc_q;
    assign id_inst = id_inst_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch front end: PC register, ROM enable, pending-redirect capture and IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = InstAddrBus,
    parameter int unsigned       INST_W   = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic [INST_W-1:0] inst_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
);

    logic [1:0]        state_d, state_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              pend_vld_d, pend_vld_q;
    logic [ADDR_W-1:0] pend_pc_d, pend_pc_q;
    logic [ADDR_W-1:0] new_pc_al, target_al;
    logic              unused_stall;

    assign unused_stall = ^stall[5:3];

    assign new_pc_al = {new_pc[ADDR_W-1:2], 2'b00};
    assign target_al = {branch_target_address_i[ADDR_W-1:2], 2'b00};

    assign ce = (state_q != StRst) ? ChipEnable : ChipDisable;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        if (state_q == StRst) begin
            state_d = StRun;
        end else if (flush) begin
            state_d    = StRun;
            pc_d       = new_pc_al;
            pend_vld_d = 1'b0;
        end else if (stall[0] == Stop) begin
            state_d = StHold;
            // Only the first redirect seen during a stall is kept.
            if (branch_flag_i && !pend_vld_q) begin
                pend_pc_d  = target_al;
                pend_vld_d = 1'b1;
            end
        end else begin
            state_d = StRun;
            if (pend_vld_q) begin
                pc_d       = pend_pc_q;
                pend_vld_d = 1'b0;
            end else if (branch_flag_i) begin
                pc_d = target_al;
            end else begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= StRst;
            pc_q       <= RESET_PC;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign pc = pc_q;

    if_stage_if_id #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .flush   (flush),
        .stall   (stall[2:1]),
        .pc      (pc_q),
        .inst    (inst_i),
        .id_pc   (id_pc),
        .id_inst (id_inst)
    );

endmodule
